// File: rtl/ppu_pkg.sv
// Shared types for the PPU VRAM/palette arbiter: request record, FSM states, palette decode.
// Pure declarations, no timing or flow control of its own.
package ppu_pkg;

  localparam logic [5:0] PAL_PAGE = 6'h3F;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
  } cpu_req_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_RDWAIT = 1'b1
  } arb_state_e;

  function automatic logic is_pal(input logic [13:0] addr);
    return addr[13:8] == PAL_PAGE;
  endfunction

  // Sprite-palette entry 0 of each group aliases the matching background entry.
  function automatic logic [4:0] pal_index(input logic [13:0] addr);
    logic [4:0] idx;
    idx = addr[4:0];
    if (idx[4] && (idx[1:0] == 2'b00)) begin
      idx[4] = 1'b0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ppu_vram_arbiter_if.sv
// CPU request/response, renderer sideband and VRAM/palette memory ports of the arbiter.
// master = arbiter side, slave = CPU/renderer/memory side.
interface ppu_vram_arbiter_if;

  logic        render_active;
  logic        rnd_idle;
  logic [15:0] rnd_vram_addr;
  logic [4:0]  rnd_pal_addr;

  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;

  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  logic [4:0]  pal_addr;
  logic        pal_we;
  logic [7:0]  pal_wdata;
  logic [7:0]  pal_rdata;

  modport master (
    input  render_active, rnd_idle, rnd_vram_addr, rnd_pal_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rvalid, cpu_rdata,
    output vram_addr, vram_we, vram_wdata,
    input  vram_rdata,
    output pal_addr, pal_we, pal_wdata,
    input  pal_rdata
  );

  modport slave (
    output render_active, rnd_idle, rnd_vram_addr, rnd_pal_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata,
    input  vram_addr, vram_we, vram_wdata,
    output vram_rdata,
    input  pal_addr, pal_we, pal_wdata,
    output pal_rdata
  );

endinterface

// File: rtl/ppu_req_fifo.sv
// In-order CPU request buffer; pushed entry visible at the head the cycle after the push.
// No internal backpressure: caller must not push when full nor pop when empty.
module ppu_req_fifo
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  cpu_req_t push_dat,
  input  logic     pop,
  output cpu_req_t head_dat,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  cpu_req_t    mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  // Extra pointer bit tells full from empty when the indices coincide.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Queues CPU VRAM/palette accesses and issues them in order when the renderer leaves the memory free.
// Writes issue 1 cycle after acceptance at best; read data returns 2 cycles after issue; cpu_ready = !full.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ppu_vram_arbiter_if.master   bus
);

  localparam logic [0:0] IDLE   = ARB_IDLE;
  localparam logic [0:0] RDWAIT = ARB_RDWAIT;

  logic [0:0] state;
  cpu_req_t   push_dat;
  cpu_req_t   head;
  logic       full;
  logic       empty;
  logic       push;
  logic       issue;
  logic       head_pal;
  logic [4:0] head_pidx;
  logic       grant;
  logic       rd_pal;
  logic [4:0] pal_addr_q;
  logic       rvalid_q;
  logic [7:0] rdata_q;
  logic       addr_hi_unused;

  assign addr_hi_unused = ^bus.cpu_addr[15:14];

  assign push     = bus.cpu_req && !full;
  assign push_dat = '{we: bus.cpu_we, addr: bus.cpu_addr[13:0], wdata: bus.cpu_wdata};

  ppu_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (issue),
    .head_dat (head),
    .full     (full),
    .empty    (empty)
  );

  assign head_pal  = is_pal(head.addr);
  assign head_pidx = pal_index(head.addr);

  // Palette is only free outside rendering; VRAM also frees up in renderer idle gaps.
  assign grant = head_pal ? !bus.render_active : (!bus.render_active || bus.rnd_idle);
  assign issue = (state == IDLE) && !empty && grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rd_pal     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 8'h00;
      pal_addr_q <= 5'h00;
    end else begin
      rvalid_q <= (state == RDWAIT);
      case (state)
        IDLE: begin
          if (issue && !head.we) begin
            state  <= RDWAIT;
            rd_pal <= head_pal;
          end
        end
        RDWAIT: begin
          rdata_q <= rd_pal ? bus.pal_rdata : bus.vram_rdata;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (issue && head_pal) begin
        pal_addr_q <= head_pidx;
      end
    end
  end

  assign bus.cpu_ready  = !full;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_rdata  = rdata_q;

  assign bus.vram_addr  = (issue && !head_pal) ? {2'b00, head.addr} : bus.rnd_vram_addr;
  assign bus.vram_we    = issue && !head_pal && head.we;
  assign bus.vram_wdata = head.wdata;

  assign bus.pal_addr   = (issue && head_pal) ? head_pidx
                        : (bus.render_active ? bus.rnd_pal_addr : pal_addr_q);
  assign bus.pal_we     = issue && head_pal && head.we;
  assign bus.pal_wdata  = head.wdata;

endmodule

// File: doc/ppu_vram_arbiter.md
PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the CPU request buffer depth (power of 2, >=2).
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous active-low reset.
REQ-004 render_active  in  1  SHALL be high when the renderer owns VRAM and palette (visible scanlines, bg or spr enabled).
REQ-005 rnd_idle  in  1  SHALL be high on cycles the renderer does not need VRAM, such as hblank gaps.
REQ-006 rnd_vram_addr  in  16  SHALL carry the renderer VRAM address; rnd_pal_addr  in  5  SHALL carry the renderer pixel palette index.
REQ-007 cpu_req  in  1  / cpu_we  in  1  / cpu_addr  in  16  / cpu_wdata  in  8  SHALL form the CPU (register-interface) request.
REQ-008 cpu_ready  out  1  SHALL indicate that a request is accepted this cycle when cpu_req is high.
REQ-009 cpu_rvalid  out  1  / cpu_rdata  out  8  SHALL return read data as a one-cycle pulse.
REQ-010 vram_addr  out  16  / vram_we  out  1  / vram_wdata  out  8  / vram_rdata  in  8  SHALL drive the VRAM (1-cycle synchronous read).
REQ-011 pal_addr  out  5  / pal_we  out  1  / pal_wdata  out  8  / pal_rdata  in  8  SHALL drive palette memory (1-cycle synchronous read).

Function
REQ-012 The block SHALL accept a request when cpu_req && cpu_ready and store {we, addr[13:0], wdata} in an in-order FIFO; cpu_ready SHALL equal !full.
REQ-013 A request with addr[13:8]==6'h3F SHALL target palette; all others SHALL target VRAM at addr[13:0] zero-extended.
REQ-014 Palette index SHALL be addr[4:0], with 5'h10/14/18/1C mapped to 5'h00/04/08/0C.
REQ-015 VRAM grant SHALL be (!render_active || rnd_idle); palette grant SHALL be !render_active only.
REQ-016 FSM states SHALL be IDLE, RDWAIT.
REQ-017 IDLE with the FIFO non-empty and the head's target granted SHALL issue the head that cycle: drive its address to the target, pop it, assert the target WE for a write; a read SHALL go to RDWAIT.
REQ-018 RDWAIT SHALL register the target rdata into cpu_rdata, pulse cpu_rvalid next cycle, and return to IDLE with no new issue that cycle.
REQ-019 Read latency SHALL be fixed: read issued in cycle N -> cpu_rvalid high in cycle N+2.
REQ-020 Writes SHALL issue back-to-back, one per cycle, while granted.
REQ-021 An ungranted head SHALL block younger requests (no reordering).
REQ-022 When no CPU issue occurs, vram_addr SHALL equal rnd_vram_addr, pal_addr SHALL equal rnd_pal_addr when render_active (else last CPU palette address), and both WEs SHALL be 0.
REQ-023 Grant SHALL be evaluated combinationally in the issue cycle; render_active rising during RDWAIT SHALL NOT cancel the pending read.
REQ-024 A push and a pop in the same cycle SHALL leave the occupancy unchanged; a push when full SHALL be impossible because cpu_ready is low.
REQ-025 A request accepted in cycle N SHALL be issuable no earlier than cycle N+1.

Reset
REQ-026 Asserted reset SHALL empty the FIFO and force IDLE, with cpu_ready=1, cpu_rvalid=0, cpu_rdata=0, vram_we=0, pal_we=0, and pal_addr register=0.
REQ-027 Reset asserted mid-read SHALL discard the read with no cpu_rvalid pulse after release.

Structure
REQ-028 Package ppu_pkg SHALL hold PAL_PAGE (6'h3F), the request struct typedef {we, addr[13:0], wdata[7:0]}, and the arbiter state enum.
REQ-029 The FIFO SHALL be a sub-module named ppu_req_fifo, parameterised by FIFO_DEPTH.

Verification
REQ-030 Write 8'hA5 to 16'h2000 with render_active=0 -> vram_we=1, vram_addr=16'h2000, vram_wdata=8'hA5 in cycle after acceptance.
REQ-031 Read 16'h23C0 (VRAM holds 8'h5A) with render_active=0 -> cpu_rvalid pulse with cpu_rdata=8'h5A exactly 2 cycles after issue.
REQ-032 Write 8'h0F to 16'h3F10 -> pal_we=1, pal_addr=5'h00, vram_we=0.
REQ-033 render_active=1, rnd_idle=0, push 5 writes (depth 4) -> cpu_ready=0 after 4, no WE, vram_addr tracks rnd_vram_addr; rnd_idle=1 for 2 cycles -> exactly 2 writes issue in order.
REQ-034 render_active=1, rnd_idle=1, head is palette write, then a VRAM write -> neither issues until render_active=0, then palette first.
REQ-035 Issue read, assert reset in RDWAIT, release -> no cpu_rvalid, cpu_ready=1, FIFO empty.
